// File: rtl/ram_stream_pkg.sv
// ---------------------------------------------------------------------------
// ram_stream_pkg
// Shared definitions for the RAM stream reader: default widths and the
// controller state encoding.
// ---------------------------------------------------------------------------
package ram_stream_pkg;

   localparam int DATA_WIDTH_DEFAULT = 32;
   localparam int ADDR_WIDTH_DEFAULT = 7;

   // IDLE waits for a command, FETCH captures the RAM word, SEND offers it
   // downstream, DONE produces the completion pulse.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// ram_stream_reader_if
// Bundles the command, RAM and stream signals of ram_stream_reader so an
// environment can wire the reader with a single handle.
//   command : start, start_addr, length, busy, done, checksum
//   RAM     : mem_addr, mem_we, mem_q (asynchronous read data)
//   stream  : out_data, out_valid, out_ready, out_last
// master = the side that issues commands, provides RAM data and sinks the
// stream; slave = the reader itself.
// ---------------------------------------------------------------------------
interface ram_stream_reader_if
   import ram_stream_pkg::*;
#(
   parameter int Data_width = DATA_WIDTH_DEFAULT,
   parameter int Addr_width = ADDR_WIDTH_DEFAULT
) ();

   logic                  start;
   logic [Addr_width-1:0] start_addr;
   logic [Addr_width:0]   length;
   logic [Addr_width-1:0] mem_addr;
   logic                  mem_we;
   logic [Data_width-1:0] mem_q;
   logic [Data_width-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;
   logic                  busy;
   logic                  done;
   logic [Data_width-1:0] checksum;

   modport master (
      output start, start_addr, length, mem_q, out_ready,
      input  mem_addr, mem_we, out_data, out_valid, out_last, busy, done, checksum
   );

   modport slave (
      input  start, start_addr, length, mem_q, out_ready,
      output mem_addr, mem_we, out_data, out_valid, out_last, busy, done, checksum
   );

endinterface

// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
// Reads `length` consecutive words from an external asynchronous-read RAM,
// starting at `start_addr` (address wraps at the top of the RAM), and sends
// them as a valid/ready stream, flagging the final word with out_last. A
// running checksum of accepted words is kept and held after completion;
// `done` pulses once per command.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, start_addr,  command strobe (IDLE only), first address,
//   length              word count 0..2**Addr_width
//   mem_addr, mem_we,   RAM address, write enable (always 0),
//   mem_q               RAM read data for mem_addr
//   out_data, out_valid stream word and qualifier
//   out_ready, out_last downstream accept, final-word flag
//   busy, done,         not-IDLE flag, one-cycle completion pulse,
//   checksum            sum of accepted words modulo 2**Data_width
// ---------------------------------------------------------------------------
module ram_stream_reader
   import ram_stream_pkg::*;
#(
   parameter int Data_width = DATA_WIDTH_DEFAULT,
   parameter int Addr_width = ADDR_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [Addr_width-1:0] start_addr,
   input  logic [Addr_width:0]   length,
   output logic [Addr_width-1:0] mem_addr,
   output logic                  mem_we,
   input  logic [Data_width-1:0] mem_q,
   output logic [Data_width-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic [Data_width-1:0] checksum
);

   state_t                state, state_nxt;
   logic [Addr_width-1:0] addr, addr_nxt;
   logic [Addr_width:0]   remaining, remaining_nxt;
   logic [Data_width-1:0] data_nxt, sum_nxt;
   logic                  valid_nxt, last_nxt, done_nxt;

   assign mem_addr = addr;
   assign mem_we   = 1'b0;
   assign busy     = (state != IDLE);

   // NOTE: every signal gets its hold value first so no path through the
   // case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt     = state;
      addr_nxt      = addr;
      remaining_nxt = remaining;
      data_nxt      = out_data;
      valid_nxt     = out_valid;
      last_nxt      = out_last;
      done_nxt      = 1'b0;
      sum_nxt       = checksum;
      case (state)
         IDLE: begin
            if (start) begin
               sum_nxt = '0;
               if (length != '0) begin
                  addr_nxt      = start_addr;
                  remaining_nxt = length;
                  state_nxt     = FETCH;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         FETCH: begin
            data_nxt  = mem_q;
            valid_nxt = 1'b1;
            last_nxt  = (remaining == {{Addr_width{1'b0}}, 1'b1});
            state_nxt = SEND;
         end
         SEND: begin
            // Word is held untouched until the consumer takes it.
            if (out_ready) begin
               sum_nxt   = checksum + out_data;
               valid_nxt = 1'b0;
               last_nxt  = 1'b0;
               if (out_last) begin
                  state_nxt = DONE;
               end else begin
                  // Natural overflow of addr gives the wrap to address 0.
                  addr_nxt      = addr + 1'b1;
                  remaining_nxt = remaining - 1'b1;
                  state_nxt     = FETCH;
               end
            end
         end
         DONE: begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         checksum  <= '0;
      end else begin
         state     <= state_nxt;
         addr      <= addr_nxt;
         remaining <= remaining_nxt;
         out_data  <= data_nxt;
         out_valid <= valid_nxt;
         out_last  <= last_nxt;
         done      <= done_nxt;
         checksum  <= sum_nxt;
      end
   end

endmodule
